// File: rtl/parking_gate_ctrl.sv
// Gate-side event source for the parking board: debounces entry/exit loops, drives barriers and one-cycle car strobes.
// Optional per-gate event counters are enabled with GATE_EVENT_COUNT_EN.
module parking_gate_ctrl #(
    parameter int DEBOUNCE     = 4,
    parameter int OPEN_TIMEOUT = 600,
    parameter int CNT_W        = 10
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        entry_detect,
    input  logic        entry_is_uni,
    input  logic        exit_detect,
    input  logic        exit_is_uni,
    input  logic        uni_is_vacated_space,
    input  logic        is_vacated_space,
    output logic        entry_barrier_open,
    output logic        entry_denied,
    output logic        exit_barrier_open,
    output logic        carin,
    output logic        is_uni_carin,
    output logic        carout,
    output logic        is_uni_carout
`ifdef GATE_EVENT_COUNT_EN
    ,
    output logic [15:0] entry_count,
    output logic [15:0] exit_count
`endif
);

    typedef enum logic [2:0] {
        S_IDLE, S_DBNC, S_CHECK, S_OPEN, S_DENY, S_WAIT_CLR
    } state_t;

    localparam logic [CNT_W-1:0] C_DBNC_LAST = CNT_W'(DEBOUNCE - 1);
    localparam logic [CNT_W-1:0] C_TO_LAST   = CNT_W'(OPEN_TIMEOUT - 1);
    localparam logic [CNT_W-1:0] C_CNT_MAX   = '1;

    // Index 0 is the entry gate, index 1 the exit gate (which never lacks vacancy).
    logic [1:0] w_detect;
    logic [1:0] w_is_uni;
    logic [1:0] w_vacant;
    logic [1:0] w_open;
    logic [1:0] w_denied;
    logic [1:0] w_strobe;
    logic [1:0] w_strobe_uni;

    assign w_detect = {exit_detect, entry_detect};
    assign w_is_uni = {exit_is_uni, entry_is_uni};
    assign w_vacant = {1'b1, (entry_is_uni ? uni_is_vacated_space : is_vacated_space)};

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : gen_gate
            state_t           r_state;
            state_t           w_state_next;
            logic [CNT_W-1:0] r_cnt;
            logic [CNT_W-1:0] w_cnt_next;
            logic [CNT_W-1:0] w_cnt_inc;
            logic             r_uni;
            logic             w_uni_next;
            logic             r_open;
            logic             r_denied;
            logic             r_strobe;
            logic             r_strobe_uni;
            logic             w_open_next;
            logic             w_denied_next;
            logic             w_strobe_next;
            logic             w_strobe_uni_next;

            assign w_cnt_inc = (r_cnt == C_CNT_MAX) ? r_cnt : r_cnt + 1'b1;

            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    r_state      <= S_IDLE;
                    r_cnt        <= '0;
                    r_uni        <= 1'b0;
                    r_open       <= 1'b0;
                    r_denied     <= 1'b0;
                    r_strobe     <= 1'b0;
                    r_strobe_uni <= 1'b0;
                end else begin
                    r_state      <= w_state_next;
                    r_cnt        <= w_cnt_next;
                    r_uni        <= w_uni_next;
                    r_open       <= w_open_next;
                    r_denied     <= w_denied_next;
                    r_strobe     <= w_strobe_next;
                    r_strobe_uni <= w_strobe_uni_next;
                end
            end

            always_comb begin
                w_state_next = r_state;
                w_cnt_next   = r_cnt;
                w_uni_next   = r_uni;
                case (r_state)
                    S_IDLE: begin
                        if (w_detect[gi]) begin
                            w_cnt_next   = CNT_W'(1);
                            w_state_next = (DEBOUNCE <= 1) ? S_CHECK : S_DBNC;
                        end
                    end
                    S_DBNC: begin
                        if (!w_detect[gi]) begin
                            w_state_next = S_IDLE;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                            if (r_cnt >= C_DBNC_LAST) begin
                                w_state_next = S_CHECK;
                            end
                        end
                    end
                    S_CHECK: begin
                        // Category and vacancy are frozen here; later changes are ignored.
                        w_uni_next   = w_is_uni[gi];
                        w_cnt_next   = '0;
                        w_state_next = w_vacant[gi] ? S_OPEN : S_DENY;
                    end
                    S_OPEN: begin
                        if (!w_detect[gi]) begin
                            w_state_next = S_IDLE;
                            w_cnt_next   = '0;
                        end else if (r_cnt >= C_TO_LAST) begin
                            w_state_next = S_WAIT_CLR;
                            w_cnt_next   = '0;
                        end else begin
                            w_cnt_next = w_cnt_inc;
                        end
                    end
                    S_DENY, S_WAIT_CLR: begin
                        if (!w_detect[gi]) begin
                            w_state_next = S_IDLE;
                        end
                    end
                    default: begin
                        w_state_next = S_IDLE;
                        w_cnt_next   = '0;
                    end
                endcase
            end

            always_comb begin
                w_open_next       = (w_state_next == S_OPEN);
                w_denied_next     = (w_state_next == S_DENY) && w_detect[gi];
                w_strobe_next     = (r_state == S_OPEN) && !w_detect[gi];
                w_strobe_uni_next = w_strobe_next && r_uni;
            end

            assign w_open[gi]       = r_open;
            assign w_denied[gi]     = r_denied;
            assign w_strobe[gi]     = r_strobe;
            assign w_strobe_uni[gi] = r_strobe_uni;
        end
    endgenerate

    assign entry_barrier_open = w_open[0];
    assign entry_denied       = w_denied[0];
    assign exit_barrier_open  = w_open[1];
    assign carin              = w_strobe[0];
    assign is_uni_carin       = w_strobe_uni[0];
    assign carout             = w_strobe[1];
    assign is_uni_carout      = w_strobe_uni[1];

`ifdef GATE_EVENT_COUNT_EN
    logic [15:0] r_entry_count;
    logic [15:0] r_exit_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_entry_count <= '0;
            r_exit_count  <= '0;
        end else begin
            if (w_strobe[0]) r_entry_count <= r_entry_count + 16'd1;
            if (w_strobe[1]) r_exit_count  <= r_exit_count + 16'd1;
        end
    end

    assign entry_count = r_entry_count;
    assign exit_count  = r_exit_count;
`endif

endmodule
